// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode constants and default frame geometry.
// Also used by spi_receiver so both ends of the link agree on framing.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } spi_state_e;

   // Only SPI mode 0 is implemented.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   localparam int unsigned SPI_DATA_W  = 8;
   localparam int unsigned SPI_CLK_DIV = 4;
   localparam int unsigned SPI_CS_GAP  = 2;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for SPI clock generation: counts 0..CLK_DIV-1 while enabled
// and raises a combinational tick on the terminal count.
module spi_clk_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_clk_div: CLK_DIV must be 2 or more");
   end

   logic [CNT_W-1:0] cnt;

   assign tick_c = en && (cnt == CNT_MAX);

   // Wraps on tick; cleared while idle or when the owning FSM changes state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || !en || tick_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_transmitter.sv
// Byte-oriented SPI master (mode 0, MSB first): one CS-framed transfer per accepted
// word, full-duplex capture of MISO with a one-cycle received-word strobe.
module spi_transmitter
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W  = SPI_DATA_W,
   parameter int unsigned CLK_DIV = SPI_CLK_DIV,
   parameter int unsigned CS_GAP  = SPI_CS_GAP
) (
   input  logic              _i_clk,
   input  logic              _i_rst,
   input  logic [DATA_W-1:0] _i_data,
   input  logic              _i_valid,
   input  logic              _i_miso,
   output logic              o_ready,
   output logic              o_sclk,
   output logic              o_mosi,
   output logic              o_cs_n,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid
);

   localparam int unsigned BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   if (DATA_W < 2) begin : g_bad_width
      $error("spi_transmitter: DATA_W must be 2 or more");
   end
   if (CS_GAP < 1) begin : g_bad_gap
      $error("spi_transmitter: CS_GAP must be 1 or more");
   end
   if ((SPI_CPOL != 1'b0) || (SPI_CPHA != 1'b0)) begin : g_bad_mode
      $error("spi_transmitter: only SPI mode 0 is supported");
   end

   spi_state_e        state, state_nxt;
   logic [DATA_W-1:0] tx_shift, tx_nxt;
   logic [DATA_W-1:0] rx_shift, rx_nxt;
   logic [BIT_W-1:0]  bit_cnt, bit_nxt;
   logic [GAP_W-1:0]  gap_cnt, gap_nxt;
   logic              ready_nxt, sclk_nxt, mosi_nxt, cs_nxt, rx_valid_nxt;
   logic [DATA_W-1:0] rx_data_nxt;
   logic              tick_c, cnt_clr_c, cnt_en_c;

   // Counter restarts on every state entry and only runs outside IDLE.
   assign cnt_clr_c = (state_nxt != state);
   assign cnt_en_c  = (state != IDLE);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk    (_i_clk),
      .rst_n  (_i_rst),
      .clr    (cnt_clr_c),
      .en     (cnt_en_c),
      .tick_c (tick_c)
   );

   always_ff @(posedge _i_clk or negedge _i_rst) begin
      if (!_i_rst) begin
         state      <= IDLE;
         tx_shift   <= '0;
         rx_shift   <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         o_ready    <= 1'b1;
         o_sclk     <= SPI_CPOL;
         o_mosi     <= 1'b0;
         o_cs_n     <= 1'b1;
         o_rx_data  <= '0;
         o_rx_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         tx_shift   <= tx_nxt;
         rx_shift   <= rx_nxt;
         bit_cnt    <= bit_nxt;
         gap_cnt    <= gap_nxt;
         o_ready    <= ready_nxt;
         o_sclk     <= sclk_nxt;
         o_mosi     <= mosi_nxt;
         o_cs_n     <= cs_nxt;
         o_rx_data  <= rx_data_nxt;
         o_rx_valid <= rx_valid_nxt;
      end
   end

   // Next-state and next-output logic; every registered output is computed here.
   always_comb begin
      state_nxt    = state;
      tx_nxt       = tx_shift;
      rx_nxt       = rx_shift;
      bit_nxt      = bit_cnt;
      gap_nxt      = gap_cnt;
      ready_nxt    = o_ready;
      sclk_nxt     = o_sclk;
      mosi_nxt     = o_mosi;
      cs_nxt       = o_cs_n;
      rx_data_nxt  = o_rx_data;
      rx_valid_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (_i_valid && o_ready) begin
               tx_nxt    = _i_data;
               cs_nxt    = 1'b0;
               mosi_nxt  = _i_data[DATA_W-1];
               ready_nxt = 1'b0;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (tick_c) begin
               sclk_nxt  = 1'b1;
               rx_nxt    = {rx_shift[DATA_W-2:0], _i_miso};
               bit_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (tick_c) begin
               sclk_nxt = ~o_sclk;
               if (!o_sclk) begin
                  rx_nxt = {rx_shift[DATA_W-2:0], _i_miso};
               end else if (bit_cnt == BIT_LAST) begin
                  cs_nxt       = 1'b1;
                  mosi_nxt     = 1'b0;
                  rx_data_nxt  = rx_shift;
                  rx_valid_nxt = 1'b1;
                  gap_nxt      = '0;
                  state_nxt    = GAP;
               end else begin
                  tx_nxt   = {tx_shift[DATA_W-2:0], 1'b0};
                  mosi_nxt = tx_shift[DATA_W-2];
                  bit_nxt  = bit_cnt + BIT_W'(1);
               end
            end
         end
         GAP: begin
            if (tick_c) begin
               if (gap_cnt == GAP_LAST) begin
                  ready_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  gap_nxt = gap_cnt + GAP_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_transmitter.sv
// Scoreboard bench for spi_transmitter: a word-level peripheral model supplies MISO,
// a monitor rebuilds MOSI words, checks frame timing and pops expected words.
module tb_spi_transmitter;

   localparam int W    = 8;
   localparam int DIV  = 4;
   localparam int GAP  = 2;
   localparam int DIV1 = 2;
   localparam int GAP1 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int e = 0;
   always @(posedge clk) e <= e + 1;

   logic [W-1:0] d0_data, d0_rx_data, d1_data, d1_rx_data;
   logic d0_valid, d0_miso, d0_ready, d0_sclk, d0_mosi, d0_cs_n, d0_rx_valid;
   logic d1_valid, d1_miso, d1_ready, d1_sclk, d1_mosi, d1_cs_n, d1_rx_valid;

   spi_transmitter #(.DATA_W(W), .CLK_DIV(DIV), .CS_GAP(GAP)) u_d0 (
      ._i_clk(clk), ._i_rst(rst_n), ._i_data(d0_data), ._i_valid(d0_valid),
      ._i_miso(d0_miso), .o_ready(d0_ready), .o_sclk(d0_sclk), .o_mosi(d0_mosi),
      .o_cs_n(d0_cs_n), .o_rx_data(d0_rx_data), .o_rx_valid(d0_rx_valid));

   spi_transmitter #(.DATA_W(W), .CLK_DIV(DIV1), .CS_GAP(GAP1)) u_d1 (
      ._i_clk(clk), ._i_rst(rst_n), ._i_data(d1_data), ._i_valid(d1_valid),
      ._i_miso(d1_miso), .o_ready(d1_ready), .o_sclk(d1_sclk), .o_mosi(d1_mosi),
      .o_cs_n(d1_cs_n), .o_rx_data(d1_rx_data), .o_rx_valid(d1_rx_valid));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic [W-1:0] tx_q[$];
   logic [W-1:0] rx_q[$];
   logic [W-1:0] periph_q[$];
   bit loop_mode = 1'b0;
   int exp_frames = 0;

   // Peripheral model: presents its word MSB first, advancing after each SCLK fall.
   logic [W-1:0] periph_word = '0;
   int fall_cnt = 0;
   always @(negedge d0_cs_n) begin
      fall_cnt = 0;
      if (!loop_mode && periph_q.size() > 0) periph_word = periph_q.pop_front();
      else periph_word = '0;
   end
   always @(negedge d0_sclk) fall_cnt = fall_cnt + 1;
   always_comb d0_miso = loop_mode ? d0_mosi :
                         ((fall_cnt < W) ? periph_word[3'(W - 1 - fall_cnt)] : 1'b0);
   always_comb d1_miso = d1_mosi;

   // Monitor for d0, sampled mid-cycle; e is the index of the latest rising edge.
   logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_ready = 1'b1, prev_mosi = 1'b0, prev_rxv = 1'b0;
   int acc_edge = 0, cs_rise_edge = 0, last_toggle = 0, rises = 0, bad_period = 0;
   int inv_err = 0, rx_pulses = 0, b2b_edge = 0;
   bit fr_active = 0, wait_ready = 0, b2b_pend = 0;
   logic [W-1:0] mosi_word = '0;
   logic [W-1:0] exp_w;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cs = 1'b1; prev_sclk = 1'b0; prev_ready = 1'b1; prev_mosi = 1'b0; prev_rxv = 1'b0;
         fr_active = 0; wait_ready = 0; b2b_pend = 0;
      end else begin
         if (d0_cs_n && d0_sclk) inv_err++;
         if (prev_sclk && d0_sclk && (d0_mosi != prev_mosi)) inv_err++;
         if (!prev_ready && d0_ready && d0_valid) begin b2b_pend = 1; b2b_edge = e; end
         if (d0_valid && d0_ready) acc_edge = e + 1;
         if (prev_cs && !d0_cs_n) begin
            chk("cs_fall_edge", e, acc_edge);
            if (b2b_pend) begin chk("b2b_accept_edge", e, b2b_edge + 1); b2b_pend = 0; end
            fr_active = 1; rises = 0; bad_period = 0; mosi_word = '0; last_toggle = e;
         end
         if (fr_active && (d0_sclk != prev_sclk)) begin
            if (d0_sclk) begin
               if (rises == 0) chk("first_sclk_rise", e, acc_edge + DIV);
               else if (e - last_toggle != DIV) bad_period++;
               rises++;
               mosi_word = {mosi_word[W-2:0], d0_mosi};
            end else if (e - last_toggle != DIV) begin
               bad_period++;
            end
            last_toggle = e;
         end
         if (fr_active && !prev_cs && d0_cs_n) begin
            chk("cs_rise_edge", e, acc_edge + 2 * W * DIV);
            chk("sclk_rises", rises, W);
            chk("half_period_errs", bad_period, 0);
            chk("rx_strobe_at_cs_rise", d0_rx_valid, 1);
            if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
            else begin exp_w = tx_q.pop_front(); chk("mosi_word", mosi_word, exp_w); end
            cs_rise_edge = e; fr_active = 0; wait_ready = 1;
         end
         if (wait_ready && !prev_ready && d0_ready) begin
            chk("ready_after_gap", e, cs_rise_edge + GAP * DIV);
            wait_ready = 0;
         end
         if (prev_rxv) chk("rx_strobe_len", d0_rx_valid, 0);
         if (d0_rx_valid) begin
            rx_pulses++;
            if (rx_q.size() == 0) chk("rx_unexpected", 1, 0);
            else begin exp_w = rx_q.pop_front(); chk("rx_data", d0_rx_data, exp_w); end
         end
         prev_cs = d0_cs_n; prev_sclk = d0_sclk; prev_ready = d0_ready;
         prev_mosi = d0_mosi; prev_rxv = d0_rx_valid;
      end
   end

   task automatic send(input logic [W-1:0] w, input logic [W-1:0] pw, input bit hold);
      int n = 0;
      tx_q.push_back(w);
      rx_q.push_back(loop_mode ? w : pw);
      if (!loop_mode) periph_q.push_back(pw);
      exp_frames++;
      @(posedge clk); #1;
      d0_data = w; d0_valid = 1'b1;
      @(negedge clk);
      while (!d0_ready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      if (!hold) d0_valid = 1'b0;
      d0_data = W'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(tx_q.size() == 0 && rx_q.size() == 0 && d0_ready === 1'b1) && n < 2000) begin
         @(negedge clk); n++;
      end
      if (n >= 2000) chk("idle_timeout", 1, 0);
   endtask

   task automatic run_small_build();
      int n = 0, acc = 0, fall_e = -1, rise_e = -1, rdy_e = -1, r1 = -1, r2 = -1, rxcnt = 0;
      logic ps_cs = 1'b1, ps_sclk = 1'b0, ps_rdy = 1'b0;
      logic [W-1:0] rxd = '0;
      @(posedge clk); #1;
      d1_data = 8'h80; d1_valid = 1'b1;
      @(negedge clk);
      while (!d1_ready && n < 100) begin @(negedge clk); n++; end
      acc = e + 1;
      @(posedge clk); #1;
      d1_valid = 1'b0; d1_data = 8'h7F;
      repeat (60) begin
         @(negedge clk);
         if (ps_cs && !d1_cs_n) fall_e = e;
         if (!ps_cs && d1_cs_n && rise_e < 0) rise_e = e;
         if (d1_sclk && !ps_sclk) begin
            if (r1 < 0) r1 = e; else if (r2 < 0) r2 = e;
         end
         if (!ps_rdy && d1_ready && rdy_e < 0) rdy_e = e;
         if (d1_rx_valid) begin rxcnt++; rxd = d1_rx_data; end
         ps_cs = d1_cs_n; ps_sclk = d1_sclk; ps_rdy = d1_ready;
      end
      chk("div2_cs_fall", fall_e, acc);
      chk("div2_cs_low_cycles", rise_e - fall_e, 2 * W * DIV1);
      chk("div2_ready_latency", rdy_e - acc, 2 * W * DIV1 + GAP1 * DIV1);
      chk("div2_first_rise", r1 - acc, DIV1);
      chk("div2_sclk_period", r2 - r1, 2 * DIV1);
      chk("div2_rx_pulses", rxcnt, 1);
      chk("div2_rx_data", rxd, 8'h80);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap, r, n;
      logic ps;
      logic [W-1:0] w, pw;
      bit hold;
      d0_valid = 1'b0; d0_data = '0; d1_valid = 1'b0; d1_data = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", d0_ready, 1);
      chk("rst_cs_n", d0_cs_n, 1);
      chk("rst_sclk", d0_sclk, 0);
      chk("rst_mosi", d0_mosi, 0);
      chk("rst_rx_valid", d0_rx_valid, 0);
      chk("rst_rx_data", d0_rx_data, 0);

      send(8'hA5, 8'h00, 1'b0);
      wait_idle();

      loop_mode = 1'b1;
      snap = rx_pulses;
      send(8'h3C, 8'h00, 1'b0);
      wait_idle();
      chk("loopback_pulses", rx_pulses - snap, 1);
      loop_mode = 1'b0;

      send(8'hFF, 8'hC3, 1'b1);
      send(8'h01, 8'h5A, 1'b0);
      wait_idle();

      // Abort a frame after its third SCLK rise.
      snap = rx_pulses;
      send(8'h81, 8'h5A, 1'b0);
      r = 0; n = 0; ps = d0_sclk;
      while (r < 3 && n < 200) begin
         @(negedge clk);
         if (d0_sclk && !ps) r++;
         ps = d0_sclk; n++;
      end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("abort_ready", d0_ready, 1);
      chk("abort_cs_n", d0_cs_n, 1);
      chk("abort_sclk", d0_sclk, 0);
      chk("abort_mosi", d0_mosi, 0);
      chk("abort_rx_valid", d0_rx_valid, 0);
      chk("abort_rx_data", d0_rx_data, 0);
      tx_q.delete(); rx_q.delete(); periph_q.delete();
      exp_frames--;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      chk("no_rx_after_abort", rx_pulses, snap);
      send(8'h42, 8'h99, 1'b0);
      wait_idle();

      for (int i = 0; i < 14; i++) begin
         w = W'($urandom);
         pw = W'($urandom);
         hold = (i < 13) && ($urandom_range(0, 2) == 0);
         send(w, pw, hold);
         if (!hold) begin
            wait_idle();
            repeat ($urandom_range(0, 4)) @(posedge clk);
            loop_mode = ($urandom_range(0, 1) == 1);
         end
      end
      wait_idle();

      run_small_build();

      chk("signal_invariants", inv_err, 0);
      chk("rx_strobe_total", rx_pulses, exp_frames);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
